// File: rtl/cic_decimator_ctrl_pkg.sv
// Shared constants for the CIC rate controller: 2-bit state encoding and a
// counter-width helper that never returns a zero-width vector.
package cic_decimator_ctrl_pkg;

  localparam logic [1:0] ST_FLUSH  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  function automatic int ctrlCntWidth(input int maxVal);
    int w;
    w = $clog2(maxVal + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cic_decimator_ctrl.sv
// Run-time rate controller for cic_decimator: accepts a new rate, holds the
// CIC in reset, drops its post-reset transients, then passes the stream through.
module cic_decimator_ctrl
  import cic_decimator_ctrl_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int RMAX         = 2,
  parameter int M            = 1,
  parameter int N            = 2,
  parameter int REG_WIDTH    = WIDTH + $clog2((RMAX * M) ** N),
  parameter int DEFAULT_RATE = RMAX,
  parameter int FLUSH_CYCLES = 2,
  parameter int DISCARD      = N * M
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(RMAX+1)-1:0]   cfg_rate,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [WIDTH-1:0]            input_tdata,
  input  logic                        input_tvalid,
  output logic                        input_tready,
  output logic [WIDTH-1:0]            cic_input_tdata,
  output logic                        cic_input_tvalid,
  input  logic                        cic_input_tready,
  input  logic [REG_WIDTH-1:0]        cic_output_tdata,
  input  logic                        cic_output_tvalid,
  output logic                        cic_output_tready,
  output logic [REG_WIDTH-1:0]        output_tdata,
  output logic                        output_tvalid,
  input  logic                        output_tready,
  output logic [$clog2(RMAX+1)-1:0]   cic_rate,
  output logic                        cic_rst,
  output logic                        status_busy
);

  localparam int RW = $clog2(RMAX + 1);
  localparam int DW = ctrlCntWidth(DISCARD);
  localparam int FW = ctrlCntWidth(FLUSH_CYCLES);

  localparam int DISC_LAST_I = (DISCARD > 0) ? DISCARD - 1 : 0;
  localparam logic [DW-1:0] DISC_LAST  = DW'(DISC_LAST_I);
  localparam logic [DW-1:0] DISC_MAX   = DW'(DISCARD);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_MAX  = FW'(FLUSH_CYCLES);
  localparam logic [RW-1:0] RATE_RST   = RW'(DEFAULT_RATE);

  // Out-of-range requests are folded into 1..RMAX rather than rejected.
  function automatic logic [RW-1:0] clampRate(input logic [RW-1:0] rate);
    if (rate == '0) return RW'(1);
    if (rate > RW'(RMAX)) return RW'(RMAX);
    return rate;
  endfunction

  logic [1:0]    r_state;
  logic [RW-1:0] r_rate;
  logic [DW-1:0] r_discCnt;
  logic [FW-1:0] r_flushCnt;

  logic [1:0] w_nextState;
  logic       w_inFlush;
  logic       w_inSettle;
  logic       w_inRun;
  logic       w_accept;
  logic       w_outBeat;
  logic       w_passIn;
  logic       w_enterFlush;

  assign w_inFlush    = (r_state == ST_FLUSH);
  assign w_inSettle   = (r_state == ST_SETTLE);
  assign w_inRun      = (r_state == ST_RUN);
  assign w_accept     = cfg_valid & cfg_ready;
  assign w_outBeat    = cic_output_tvalid & cic_output_tready;
  assign w_enterFlush = (w_nextState == ST_FLUSH) & ~w_inFlush;

  // The settle exit counts the beat arriving this cycle, so the last
  // transient is swallowed and the very next beat is already forwarded.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FLUSH: begin
        if (r_flushCnt >= FLUSH_LAST) w_nextState = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (DISCARD == 0) w_nextState = ST_RUN;
        else if (w_outBeat && (r_discCnt >= DISC_LAST)) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept) w_nextState = ST_FLUSH;
      end
      default: w_nextState = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SETTLE;
      r_rate     <= RATE_RST;
      r_discCnt  <= '0;
      r_flushCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) r_rate <= clampRate(cfg_rate);
      if (w_enterFlush) begin
        r_flushCnt <= '0;
        r_discCnt  <= '0;
      end else begin
        if (w_inFlush && (r_flushCnt != FLUSH_MAX)) r_flushCnt <= r_flushCnt + 1'b1;
        if (w_inSettle && w_outBeat && (r_discCnt != DISC_MAX)) r_discCnt <= r_discCnt + 1'b1;
      end
    end
  end

  assign cfg_ready         = w_inRun & ~rst;
  assign cic_rst           = rst | w_inFlush;
  assign status_busy       = rst | ~w_inRun;
  assign cic_rate          = r_rate;

  assign w_passIn          = ~rst & (w_inSettle | w_inRun);
  assign input_tready      = w_passIn & cic_input_tready;
  assign cic_input_tvalid  = w_passIn & input_tvalid;
  assign cic_input_tdata   = input_tdata;

  assign cic_output_tready = ~rst & (w_inSettle | (w_inRun & output_tready));
  assign output_tvalid     = ~rst & w_inRun & cic_output_tvalid;
  assign output_tdata      = cic_output_tdata;

endmodule

// File: tb/tb_cic_decimator_ctrl.sv
// Bench for cic_decimator_ctrl: a behavioural 2-stage CIC sits on the CIC side,
// and downstream beats are compared with a direct-convolution reference.
module tb_cic_decimator_ctrl;

  localparam int WIDTH        = 16;
  localparam int RMAX         = 4;
  localparam int N            = 2;
  localparam int M            = 1;
  localparam int REG_WIDTH    = 20;
  localparam int RW           = 3;
  localparam int DEFAULT_RATE = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int DISCARD      = 2;

  logic                 clk;
  logic                 rst;
  logic [RW-1:0]        cfg_rate;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [WIDTH-1:0]     input_tdata;
  logic                 input_tvalid;
  logic                 input_tready;
  logic [WIDTH-1:0]     cic_input_tdata;
  logic                 cic_input_tvalid;
  logic                 cic_input_tready;
  logic [REG_WIDTH-1:0] cic_output_tdata;
  logic                 cic_output_tvalid;
  logic                 cic_output_tready;
  logic [REG_WIDTH-1:0] output_tdata;
  logic                 output_tvalid;
  logic                 output_tready;
  logic [RW-1:0]        cic_rate;
  logic                 cic_rst;
  logic                 status_busy;

  logic                 cfgValid0;
  logic                 cfgReady0;
  logic [WIDTH-1:0]     cicInData0;
  logic                 cicInValid0;
  logic                 inReady0;
  logic                 cicOutReady0;
  logic [REG_WIDTH-1:0] outData0;
  logic                 outValid0;
  logic [RW-1:0]        cicRate0;
  logic                 cicRst0;
  logic                 busy0;

  int errors = 0;
  int checks = 0;

  cic_decimator_ctrl #(
    .WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N), .REG_WIDTH(REG_WIDTH),
    .DEFAULT_RATE(DEFAULT_RATE), .FLUSH_CYCLES(FLUSH_CYCLES), .DISCARD(DISCARD)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_rate(cfg_rate), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tready(input_tready),
    .cic_input_tdata(cic_input_tdata), .cic_input_tvalid(cic_input_tvalid),
    .cic_input_tready(cic_input_tready),
    .cic_output_tdata(cic_output_tdata), .cic_output_tvalid(cic_output_tvalid),
    .cic_output_tready(cic_output_tready),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready),
    .cic_rate(cic_rate), .cic_rst(cic_rst), .status_busy(status_busy)
  );

  cic_decimator_ctrl #(
    .WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N), .REG_WIDTH(REG_WIDTH),
    .DEFAULT_RATE(DEFAULT_RATE), .FLUSH_CYCLES(FLUSH_CYCLES), .DISCARD(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .cfg_rate(3'd2), .cfg_valid(cfgValid0), .cfg_ready(cfgReady0),
    .input_tdata(16'd0), .input_tvalid(1'b0), .input_tready(inReady0),
    .cic_input_tdata(cicInData0), .cic_input_tvalid(cicInValid0),
    .cic_input_tready(1'b1),
    .cic_output_tdata(20'd0), .cic_output_tvalid(1'b0),
    .cic_output_tready(cicOutReady0),
    .output_tdata(outData0), .output_tvalid(outValid0), .output_tready(1'b1),
    .cic_rate(cicRate0), .cic_rst(cicRst0), .status_busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CIC standing in for cic_decimator (integrator/comb recursion).
  longint i1, i2, d1, d2;
  int     sCnt;
  longint stubQ[$];

  // Reference: convolution with the triangular N=2 kernel over accepted inputs.
  int     hist[$];
  longint expQ[$];
  int     expRate;

  logic   constMode, sinkAlways, lastInHs;
  logic   cfgPending;
  int     reqRate;
  int     flushLeft;
  logic   flushEnd, rstEnd;
  int     downBeats, discSeen;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampModel(input int r);
    if (r < 1) return 1;
    if (r > RMAX) return RMAX;
    return r;
  endfunction

  function automatic longint goldenAt(input int n, input int r);
    longint acc = 0;
    for (int j = 0; j < 2 * r - 1; j++) begin
      int idx = n - 1 - j;
      int h   = (j < r) ? j + 1 : 2 * r - 1 - j;
      if (idx >= 0) acc += longint'(h) * longint'(hist[idx]);
    end
    return acc;
  endfunction

  function automatic void stubDrive();
    cic_input_tready  = (stubQ.size() < 2);
    cic_output_tvalid = (stubQ.size() > 0);
    cic_output_tdata  = (stubQ.size() > 0) ? REG_WIDTH'(stubQ[0]) : '0;
  endfunction

  // One clock: drive at negedge, snapshot and check 1 ns later, update
  // the behavioural CIC and the reference 1 ns after the rising edge.
  task automatic stepCycle();
    logic inHs, stubInHs, stubOutHs, downHs, acc, cicRstS, rstS;
    int   inX, stubX, stubRate, reqS;
    longint c1, c2;
    @(negedge clk);
    if (constMode) begin
      input_tvalid = 1'b1;
      input_tdata  = 16'd100;
    end else if (!input_tvalid || lastInHs) begin
      input_tvalid = ($urandom_range(0, 9) < 7);
      input_tdata  = WIDTH'($urandom_range(0, 1000));
    end
    output_tready = sinkAlways ? 1'b1 : 1'($urandom_range(0, 1));
    cfg_valid     = cfgPending;
    cfg_rate      = RW'(reqRate);
    #1;
    inHs      = input_tvalid & input_tready;
    stubInHs  = cic_input_tvalid & cic_input_tready;
    stubOutHs = cic_output_tvalid & cic_output_tready;
    downHs    = output_tvalid & output_tready;
    acc       = cfg_valid & cfg_ready;
    cicRstS   = cic_rst;
    rstS      = rst;
    inX       = int'(input_tdata);
    stubX     = int'(cic_input_tdata);
    stubRate  = (int'(cic_rate) < 1) ? 1 : int'(cic_rate);
    reqS      = reqRate;

    if (rstS) begin
      checkOutput("rstCicRst", cic_rst, 1);
      checkOutput("rstCfgReady", cfg_ready, 0);
      checkOutput("rstInReady", input_tready, 0);
      checkOutput("rstOutValid", output_tvalid, 0);
      checkOutput("rstBusy", status_busy, 1);
    end else if (rstEnd) begin
      checkOutput("postRstRate", cic_rate, DEFAULT_RATE);
      checkOutput("postRstBusy", status_busy, 1);
      checkOutput("postRstCicRst", cic_rst, 0);
    end
    if (!rstS && flushLeft > 0) begin
      checkOutput("flushCicRst", cic_rst, 1);
      checkOutput("flushInReady", input_tready, 0);
      checkOutput("flushOutValid", output_tvalid, 0);
      checkOutput("flushCfgReady", cfg_ready, 0);
      if (flushLeft == FLUSH_CYCLES) checkOutput("flushRate", cic_rate, expRate);
    end
    if (!rstS && flushEnd) checkOutput("flushEndCicRst", cic_rst, 0);
    if (!rstS && cfg_valid && !status_busy) checkOutput("readyInRun", cfg_ready, 1);
    if (acc) checkOutput("acceptInRun", status_busy, 0);
    if (downHs) begin
      downBeats++;
      checkOutput("busyOnBeat", status_busy, 0);
      checkOutput("beatExpected", expQ.size() != 0, 1);
      if (expQ.size() != 0) checkOutput("data", output_tdata, expQ.pop_front());
    end
    if (stubOutHs && status_busy && !rstS) discSeen++;

    @(posedge clk);
    #1;
    if (cicRstS) begin
      i1 = 0; i2 = 0; d1 = 0; d2 = 0; sCnt = 0;
      stubQ.delete();
    end else begin
      if (stubOutHs) void'(stubQ.pop_front());
      if (stubInHs) begin
        i1 += stubX;
        i2 += i1;
        sCnt++;
        if (sCnt >= stubRate) begin
          sCnt = 0;
          c1 = i2 - d1; d1 = i2;
          c2 = c1 - d2; d2 = c1;
          stubQ.push_back(c2);
        end
      end
    end
    stubDrive();

    if (inHs) begin
      hist.push_back(inX);
      if (hist.size() % expRate == 0) begin
        if (hist.size() / expRate > DISCARD) expQ.push_back(goldenAt(hist.size(), expRate));
      end
    end
    lastInHs = inHs;
    rstEnd   = 1'b0;
    flushEnd = 1'b0;
    if (rstS) begin
      hist.delete(); expQ.delete();
      expRate   = DEFAULT_RATE;
      flushLeft = 0;
      rstEnd    = 1'b1;
    end else if (acc) begin
      hist.delete(); expQ.delete();
      expRate    = clampModel(reqS);
      flushLeft  = FLUSH_CYCLES;
      cfgPending = 1'b0;
      discSeen   = 0;
    end else if (flushLeft > 0) begin
      flushLeft--;
      if (flushLeft == 0) flushEnd = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int rate);
    cfgPending = 1'b1;
    reqRate    = rate;
    for (int i = 0; i < 400 && cfgPending; i++) stepCycle();
    checkOutput("cfgAccepted", !cfgPending, 1);
  endtask

  task automatic waitBeats(input int n);
    int start = downBeats;
    for (int i = 0; i < 600 && (downBeats - start) < n; i++) stepCycle();
    checkOutput("beatsArrived", (downBeats - start) >= n, 1);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_rate = '0;
    input_tvalid = 1'b0; input_tdata = '0; output_tready = 1'b1;
    cfgValid0 = 1'b0;
    constMode = 1'b1; sinkAlways = 1'b1; lastInHs = 1'b0;
    cfgPending = 1'b0; reqRate = 0;
    flushLeft = 0; flushEnd = 1'b0; rstEnd = 1'b0;
    downBeats = 0; discSeen = 0;
    i1 = 0; i2 = 0; d1 = 0; d2 = 0; sCnt = 0;
    expRate = DEFAULT_RATE;
    stubDrive();

    repeat (3) stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("d0BusyAtRelease", busy0, 1);
    stepCycle();
    checkOutput("d0RunAfterSettle", busy0, 0);

    // Constant 100: steady 1600 at rate 4, then 400 at rate 2.
    waitBeats(6);
    applyStimulus(2);
    waitBeats(6);

    // Clamping, then a request held through FLUSH/SETTLE.
    constMode = 1'b0;
    applyStimulus(0);
    waitBeats(4);
    applyStimulus(7);
    waitBeats(4);
    applyStimulus(3);
    applyStimulus(1);
    waitBeats(4);

    // Reset after the first discard of a settle.
    applyStimulus(2);
    for (int i = 0; i < 200 && discSeen < 1; i++) stepCycle();
    checkOutput("discardSeen", discSeen >= 1, 1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    waitBeats(4);

    // Random rates with a 50% sink.
    sinkAlways = 1'b0;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(20, 60)) stepCycle();
      applyStimulus(int'($urandom_range(0, 7)));
    end
    waitBeats(8);

    // DISCARD=0 build: FLUSH_CYCLES of reset, one SETTLE cycle, then RUN.
    checkOutput("d0CfgReady", cfgReady0, 1);
    cfgValid0 = 1'b1;
    stepCycle();
    cfgValid0 = 1'b0;
    checkOutput("d0Flush1", cicRst0, 1);
    stepCycle();
    checkOutput("d0Flush2", cicRst0, 1);
    stepCycle();
    checkOutput("d0SettleRst", cicRst0, 0);
    checkOutput("d0SettleBusy", busy0, 1);
    stepCycle();
    checkOutput("d0Run", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
